// File: rtl/cpu_defs.sv
// Shared CPU definitions: MS->WS pipeline bus, register/word types and CP0 addresses.
package cpu_defs;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int BE_W = XLEN / 8;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] uint32_t;

    // CP0 addresses are {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    typedef struct packed {
        uint32_t      pc;
        reg_addr_t    dest;
        logic [3:0]   rf_we;
        uint32_t      result;
        logic         mfc0;
        logic [7:0]   cp0_addr;
    } ms_to_ws_bus_t;

endpackage

// File: rtl/wb_stage_regfile_regfile_be.sv
// GPR array: one byte-enabled write port, two combinational read ports, r0 reads as zero.
module regfile_be
    import cpu_defs::*;
#(
    parameter int NREG_P = NREG,
    parameter int XLEN_P = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN_P/8-1:0]   we,
    input  reg_addr_t             waddr,
    input  logic [XLEN_P-1:0]     wdata,
    input  reg_addr_t             raddr1,
    input  reg_addr_t             raddr2,
    output logic [XLEN_P-1:0]     rdata1,
    output logic [XLEN_P-1:0]     rdata2
);

    logic [XLEN_P-1:0] r_gpr [NREG_P];

    // NOTE: the array is flops, not a RAM macro, so it is cleared by the async
    // reset; a RAM-backed version could not be reset this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG_P; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (waddr != '0) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            for (int b = 0; b < XLEN_P/8; b++) begin
                if (we[b]) begin
                    r_gpr[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : r_gpr[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : r_gpr[raddr2];

endmodule

// File: rtl/wb_stage_regfile.sv
// MIPS writeback stage: latches the retiring instruction, resolves MFC0,
// commits byte-enabled GPR writes and drives ID forwarding and debug trace.
module wb_stage_regfile
    import cpu_defs::*;
#(
    parameter int NREG_P = NREG,
    parameter int XLEN_P = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_to_ws_valid,
    input  ms_to_ws_bus_t         ms_to_ws_bus,
    output logic                  ws_allowin,
    input  logic                  ws_flush,
    output logic [7:0]            cp0_raddr,
    input  logic [XLEN_P-1:0]     cp0_rdata,
    input  reg_addr_t             rf_raddr1,
    input  reg_addr_t             rf_raddr2,
    output logic [XLEN_P-1:0]     rf_rdata1,
    output logic [XLEN_P-1:0]     rf_rdata2,
    output reg_addr_t             ws_dest,
    output logic [XLEN_P/8-1:0]   ws_rf_we,
    output logic [XLEN_P-1:0]     ws_result,
    output logic                  ws_mfc0,
    output logic [31:0]           debug_wb_pc,
    output logic [XLEN_P/8-1:0]   debug_wb_rf_we,
    output reg_addr_t             debug_wb_rf_wnum,
    output logic [XLEN_P-1:0]     debug_wb_rf_wdata
);

    logic                r_ws_valid;
    ms_to_ws_bus_t       r_bus;

    logic                w_ready_go;
    logic                w_live;
    logic [XLEN_P-1:0]   w_wdata;
    logic [XLEN_P/8-1:0] w_we_eff;

    assign w_ready_go = 1'b1;
    assign ws_allowin = !r_ws_valid || w_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_bus      <= '0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid && !ws_flush;
            if (ms_to_ws_valid) begin
                r_bus <= ms_to_ws_bus;
            end
        end
    end

    assign cp0_raddr = r_ws_valid ? r_bus.cp0_addr : 8'h00;
    assign w_live    = r_ws_valid && !ws_flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_wdata  = r_bus.mfc0 ? cp0_rdata : r_bus.result;
        w_we_eff = '0;
        if (w_live && r_bus.dest != '0) begin
            w_we_eff = r_bus.mfc0 ? '1 : r_bus.rf_we;
        end
    end

    regfile_be #(
        .NREG_P (NREG_P),
        .XLEN_P (XLEN_P)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (w_we_eff),
        .waddr  (r_bus.dest),
        .wdata  (w_wdata),
        .raddr1 (rf_raddr1),
        .raddr2 (rf_raddr2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    assign ws_dest   = (w_we_eff != '0) ? r_bus.dest : '0;
    assign ws_rf_we  = w_we_eff;
    assign ws_result = w_wdata;
    assign ws_mfc0   = w_live && r_bus.mfc0;

    assign debug_wb_pc       = r_bus.pc;
    assign debug_wb_rf_we    = w_we_eff;
    assign debug_wb_rf_wnum  = r_bus.dest;
    assign debug_wb_rf_wdata = w_wdata;

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Writeback stage of the 5-stage MIPS pipeline, together with the architectural register file it writes.
- Accepts a retiring instruction from the memory stage over a valid/allowin handshake.
- Resolves MFC0 results by reading CP0 in this stage, then commits byte-enabled writes to the GPRs.
- Serves the decode stage's two read ports and drives the ws_* forwarding signals (dest, result, byte enables, mfc0 flag) consumed by ID-stage forwarding. Also drives the debug writeback trace.

Parameters:
- NREG, 32, number of GPRs; index 0 hardwired to zero.
- XLEN, 32, data width; byte-enable width is XLEN/8.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ms_to_ws_valid  in  1  MS holds a valid instruction
- ms_to_ws_bus  in  ms_to_ws_bus_t  {pc[31:0], dest[4:0], rf_we[3:0], result[31:0], mfc0, cp0_addr[7:0]={rd,sel}}
- ws_allowin  out  1  WB accepts a new instruction this cycle
- ws_flush  in  1  exception/eret commit; kills the instruction in WB
- cp0_raddr  out  8  CP0 {rd,sel} read address for MFC0
- cp0_rdata  in  32  CP0 read data, combinational from cp0_raddr
- rf_raddr1  in  5  ID read port 1 address (rs)
- rf_raddr2  in  5  ID read port 2 address (rt)
- rf_rdata1  out  32  read data port 1
- rf_rdata2  out  32  read data port 2
- ws_dest  out  5  forward: destination register, 0 if no write
- ws_rf_we  out  4  forward: byte enables of pending write
- ws_result  out  32  forward: final write data
- ws_mfc0  out  1  forward: WB holds valid MFC0
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace byte enables
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset (async, immediate): ws_valid=0, pipeline register cleared, all 32 GPRs = 0. All outputs 0 while reset is high.
- ws_ready_go = 1. ws_allowin = !ws_valid | ws_ready_go, so it is 1 out of reset.
- On posedge, if ws_allowin: ws_valid <= ms_to_ws_valid & !ws_flush. If ms_to_ws_valid is also set, latch ms_to_ws_bus into the pipeline register.
- Latency: MS→WB is 1 cycle; the GPR write occurs on the posedge ending the WB cycle. Readers see the new value the following cycle.
- Final data: wdata = mfc0 ? cp0_rdata : result. cp0_raddr = latched cp0_addr, or 0 when !ws_valid.
- Effective write enable: we_eff = (ws_valid & !ws_flush) ? rf_we : 4'b0.
  - Forced to 0 when dest == 0.
  - Forced to 4'b1111 for MFC0 regardless of the incoming rf_we.
- GPR write: for each byte b with we_eff[b], gpr[dest][8b+7:8b] <= wdata[8b+7:8b]. Bytes not enabled are preserved. This covers LWL/LWR partial writes.
- Reads are combinational from the array. Address 0 returns 0. There is no internal write-through; same-cycle WB→ID hazards are covered by the ws_* forward outputs.
- Forward outputs:
  - ws_dest = (we_eff != 0) ? dest : 0
  - ws_rf_we = we_eff
  - ws_result = wdata
  - ws_mfc0 = ws_valid & mfc0 & !ws_flush
- Debug outputs: debug_wb_pc = pc; debug_wb_rf_we = we_eff; debug_wb_rf_wnum = dest; debug_wb_rf_wdata = wdata.
- Boundary conditions:
  - ws_flush and ms_to_ws_valid together: the WB instruction does not write, and the incoming instruction is not latched as valid.
  - Back-to-back writes to the same register: the later one wins; each commits in its own cycle.
  - Reset asserted mid-stream: the in-flight WB write is dropped and the array is cleared.
  - dest == 0 with rf_we != 0: no write, ws_dest = 0, debug_wb_rf_we = 0.

Decomposition:
- cpu_defs package (existing): ms_to_ws_bus_t struct, reg_addr_t, uint32_t, CP0 address constants.
- One sub-module: regfile_be, a 32x32 array with one byte-enable write port, two async read ports and async reset. The stage logic wraps it.

Test Plan:
- Reset then read: assert reset; read r5 and r31 → both 0; ws_allowin=1; all forward and debug outputs 0.
- Full write: valid bus {dest=8, rf_we=4'hF, result=32'hDEADBEEF}. During the WB cycle ws_dest=8 and ws_result=DEADBEEF; next cycle rf_raddr1=8 → rf_rdata1=DEADBEEF.
- Partial write: r8=DEADBEEF, then {dest=8, rf_we=4'b0011, result=32'h12345678} → r8=DEAD5678; debug_wb_rf_we=0011.
- MFC0: {mfc0=1, cp0_addr={12,0}, rf_we=0, dest=3} with cp0_rdata=32'h0040FF01. Expect cp0_raddr=8'h60, ws_mfc0=1, ws_rf_we=F, and r3=0040FF01 next cycle.
- Flush: {dest=9, rf_we=F, result=1} with ws_flush=1 in the WB cycle → r9 unchanged, ws_dest=0, ws_mfc0=0. A simultaneously offered MS instruction is not retired.
- r0 write: {dest=0, rf_we=F, result=FFFFFFFF} → rf_rdata1(0)=0, ws_dest=0, debug_wb_rf_we=0.
